// File: rtl/pc_call_stack.sv
// Hardware call/return stack for the PC path: circular buffer of {return address, flags}
// with a combinational top-of-stack view, occupancy tracking and sticky error flags.
module pc_call_stack #(
  parameter int ADDR_W   = 12,
  parameter int DEPTH    = 8,
  parameter int FLAG_W   = 2,
  parameter int OVF_MODE = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [ADDR_W-1:0]          push_addr,
  input  logic [FLAG_W-1:0]          push_flags,
  input  logic                       clr_err,
  output logic [ADDR_W-1:0]          top_addr,
  output logic [FLAG_W-1:0]          top_flags,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int ENT_W = ADDR_W + FLAG_W;

  logic [ENT_W-1:0] mem [DEPTH];
  logic [ENT_W-1:0] top_ent;

  logic [PTR_W-1:0] top_ptr;
  logic [PTR_W-1:0] ptr_inc;
  logic [PTR_W-1:0] ptr_dec;
  logic [PTR_W-1:0] top_ptr_nxt;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count_nxt;
  logic             wr_en;
  logic             set_ovf;
  logic             set_unf;

  // Explicit wrap so non-power-of-two depths never index past DEPTH-1.
  assign ptr_inc = (top_ptr == PTR_W'(DEPTH - 1)) ? '0 : top_ptr + 1'b1;
  assign ptr_dec = (top_ptr == '0) ? PTR_W'(DEPTH - 1) : top_ptr - 1'b1;

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));

  assign top_ent   = mem[top_ptr];
  assign top_addr  = empty ? '0 : top_ent[ENT_W-1:FLAG_W];
  assign top_flags = empty ? '0 : top_ent[FLAG_W-1:0];

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    top_ptr_nxt = top_ptr;
    count_nxt   = count;
    wr_en       = 1'b0;
    wr_ptr      = ptr_inc;
    set_ovf     = 1'b0;
    set_unf     = 1'b0;
    case ({push, pop})
      2'b10: begin
        if (!full) begin
          wr_en       = 1'b1;
          top_ptr_nxt = ptr_inc;
          count_nxt   = count + 1'b1;
        end else begin
          set_ovf = 1'b1;
          if (OVF_MODE != 0) begin
            // Slot above top is the oldest entry when full.
            wr_en       = 1'b1;
            top_ptr_nxt = ptr_inc;
          end
        end
      end
      2'b01: begin
        if (empty) begin
          set_unf = 1'b1;
        end else begin
          top_ptr_nxt = ptr_dec;
          count_nxt   = count - 1'b1;
        end
      end
      2'b11: begin
        wr_en = 1'b1;
        if (empty) begin
          set_unf     = 1'b1;
          top_ptr_nxt = ptr_inc;
          count_nxt   = count + 1'b1;
        end else begin
          // Tail call: replace the top entry in place.
          wr_ptr = top_ptr;
        end
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      top_ptr   <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      top_ptr   <= top_ptr_nxt;
      count     <= count_nxt;
      overflow  <= (overflow  & ~clr_err) | set_ovf;
      underflow <= (underflow & ~clr_err) | set_unf;
    end
  end

  // NOTE: the entry array has no reset; count gates visibility, so stale contents are harmless.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= {push_addr, push_flags};
    end
  end

endmodule

// File: doc/pc_call_stack.md
Name: pc_call_stack

Overview:
- Parametrised hardware call/return stack for the processor's PC path; replaces the fixed, unprotected return stack.
- Holds return addresses (pc+1 from the call instruction) and optionally the saved C/Z flags, with depth, width and overflow policy set by parameters.
- Presents the top entry combinationally, so a return instruction can select it as next PC in the same cycle it pops.
- Tracks occupancy and reports full/empty plus sticky overflow/underflow errors for the controller and debug.

Parameters:
ADDR_W, 12, width of a stored return address (matches PC width)
DEPTH, 8, number of entries; any integer >= 2, not restricted to a power of two
FLAG_W, 2, width of saved flag field (C, Z); 0 is not allowed, tie push_flags to 0 if unused
OVF_MODE, 0, overflow policy: 0 = reject push when full; 1 = wrap, overwriting the oldest entry

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous reset, active-low
push  in  1  push push_addr/push_flags this cycle (call)
pop  in  1  pop top entry this cycle (return)
push_addr  in  ADDR_W  return address to store
push_flags  in  FLAG_W  flags to store with address
clr_err  in  1  synchronous clear of sticky error bits
top_addr  out  ADDR_W  address of current top entry; 0 when empty
top_flags  out  FLAG_W  flags of current top entry; 0 when empty
count  out  $clog2(DEPTH+1)  number of valid entries, range 0..DEPTH
empty  out  1  count == 0
full  out  1  count == DEPTH
overflow  out  1  sticky: push attempted while full
underflow  out  1  sticky: pop attempted while empty

Behaviour:
- Storage: circular buffer of DEPTH entries, {addr, flags}. Top pointer and count are registered. Entry contents are not reset.
- Reset (rst low, asynchronous): count=0, top pointer=0, overflow=0, underflow=0. Hence empty=1, full=0, top_addr=0, top_flags=0. A reset asserted during any operation aborts it; no partial update survives.
- top_addr, top_flags, empty, full: combinational from registered state. top_* are forced to 0 when empty. A pop reads the old top in the same cycle; the stack updates at the clock edge.
- All updates occur on the rising clk edge. Per-cycle operation:
  - idle (push=0, pop=0): no change.
  - push only, not full: write entry above top, advance top pointer (mod DEPTH), count+1.
  - push only, full, OVF_MODE=0: no state change; overflow<=1.
  - push only, full, OVF_MODE=1: write entry above top, overwriting the oldest; advance top pointer; count stays DEPTH; overflow<=1.
  - pop only, not empty: retreat top pointer (mod DEPTH), count-1.
  - pop only, empty: no state change; underflow<=1.
  - push and pop, not empty: replace top entry in place (tail call); pointer and count unchanged; no error, even when full.
  - push and pop, empty: underflow<=1; push proceeds, count becomes 1.
- Pointer arithmetic wraps explicitly at DEPTH for non-power-of-two depths: DEPTH-1 + 1 -> 0, and 0 - 1 -> DEPTH-1.
- Sticky errors: clr_err=1 clears overflow/underflow at the edge. If a new error event occurs in the same cycle as clr_err, the set wins.
- No internal latency beyond one edge: the new top is visible on the cycle after a push or pop.

Test Plan:
- Reset then idle: with DEPTH=4, hold rst low mid-cycle -> immediately count=0, empty=1, full=0, top_addr=0, errors=0.
- Push 0x011, 0x022, 0x033 (flags 2'b01, 2'b10, 2'b11) -> count=3, top_addr=0x033, top_flags=2'b11. Pop x3 -> top_addr steps 0x022, 0x011, 0; empty=1; no errors.
- DEPTH=4, OVF_MODE=0: push 0x100..0x104 -> fifth push rejected, count=4, full=1, top_addr=0x103, overflow=1. Pop x4 -> order 0x103, 0x102, 0x101, 0x100.
- DEPTH=4, OVF_MODE=1: push 0x100..0x104 -> count=4, top_addr=0x104, overflow=1. Pop x4 -> order 0x104, 0x103, 0x102, 0x101.
- Push and pop together: with top=0x022 and count=2, push+pop with 0x0AA -> count=2, top_addr=0x0AA. On an empty stack, push+pop with 0x055 -> count=1, top_addr=0x055, underflow=1.
- Errors: pop while empty -> underflow=1 and held. clr_err alone -> 0 next cycle. clr_err together with a pop-while-empty -> underflow stays 1. Repeat with DEPTH=5 to check pointer wrap across 4->0.
